// File: rtl/merger_pkg.sv
// ----------------------------------------------------------------------------
// merger_pkg
// Shared types and constants for the coordinate merger datapath. Both the
// quaternary and binary mergers and their lane front ends use these, so a
// coordinate means the same thing everywhere in the pipeline.
//
// Contents:
//   COORD_W      - coordinate width of the merger datapath
//   SENTINEL     - all-ones coordinate, reserved to mean "no coordinate"
//   coord_t      - one coordinate
//   lane_entry_t - one buffered lane entry: end-of-fiber flag plus coordinate
// ----------------------------------------------------------------------------
package merger_pkg;

    localparam int COORD_W = 64;

    typedef logic [COORD_W-1:0] coord_t;

    // Compares greater than every legal coordinate, so an empty lane never
    // wins the merger's min-select ahead of real data.
    localparam coord_t SENTINEL = '1;

    typedef struct packed {
        logic   last;
        coord_t coord;
    } lane_entry_t;

endpackage : merger_pkg

// File: rtl/fiber_lane_buffer.sv
// ----------------------------------------------------------------------------
// fiber_lane_buffer
// Per-lane coordinate prefetch FIFO in front of one merger input. Coordinates
// arrive from the fetch unit over valid/ready, are queued in a small circular
// buffer, and the head is presented to the merger, which pops it with
// fetch_next. When nothing is stored the lane shows the all-ones sentinel.
//
// Parameters:
//   DEPTH   - FIFO entries (power of two, >= 2)
//   COORD_W - coordinate width, must match the merger datapath
//   CNT_W   - occupancy counter width
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-high reset
//   in_valid   - upstream coordinate valid
//   in_ready   - buffer can accept (not full); depends on stored state only
//   in_coord   - incoming coordinate (all-ones is reserved)
//   in_last    - final coordinate of the fiber
//   coord      - head coordinate, or SENTINEL when empty
//   fetch_next - merger pop request for the head entry
//   empty      - no stored entries
//   fiber_done - the last-flagged entry has been popped
//   underflow  - sticky: pop requested while empty before the fiber ended
//   count      - current occupancy
// ----------------------------------------------------------------------------
module fiber_lane_buffer
    import merger_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int COORD_W = merger_pkg::COORD_W,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_coord,
    input  logic               in_last,
    output logic [COORD_W-1:0] coord,
    input  logic               fetch_next,
    output logic               empty,
    output logic               fiber_done,
    output logic               underflow,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Local entry type so the lane can be built at any COORD_W; at the
    // default width it is bit-identical to merger_pkg::lane_entry_t.
    typedef struct packed {
        logic               last;
        logic [COORD_W-1:0] coord;
    } entry_t;

    localparam logic [COORD_W-1:0] LANE_SENTINEL = '1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push;
    logic             pop;
    entry_t           head;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // Derived from count alone: the merger's pop never ripples back upstream.
    assign in_ready = !full;

    assign push = in_valid && in_ready;
    // A pop while empty is dropped: the merger was looking at the sentinel.
    assign pop  = fetch_next && !empty;

    assign head  = mem[rd_ptr];
    assign coord = empty ? LANE_SENTINEL : head.coord;

    // NOTE: the storage array has no reset; its contents are only ever read
    // behind a non-zero count, so clearing it would just cost reset fan-out.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{last: in_last, coord: in_coord};
        end
    end

    // NOTE: all state here uses non-blocking assignments so every branch sees
    // the pre-edge values of count, fiber_done and the pointers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fiber_done <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so +1 wraps at DEPTH-1.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Popping the end of a fiber wins over a push starting the next
            // one on the same edge; that new entry simply waits behind it.
            if (pop && head.last) begin
                fiber_done <= 1'b1;
            end else if (push) begin
                fiber_done <= 1'b0;
            end

            // After fiber_done the merger may keep asking an empty lane while
            // other lanes drain; only a request before the fiber ended is bad.
            if (fetch_next && empty && !fiber_done) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule : fiber_lane_buffer

// File: tb/tb_fiber_lane_buffer.sv
// ----------------------------------------------------------------------------
// tb_fiber_lane_buffer
// Directed bench for fiber_lane_buffer (DEPTH=4, COORD_W=64). A table of
// per-cycle vectors drives the inputs for one clock edge and lists the
// outputs expected just after that edge. Hand-written sequences cover the
// asynchronous reset and the no-bypass property, which need sub-cycle timing.
// ----------------------------------------------------------------------------
module tb_fiber_lane_buffer;

    localparam int DEPTH   = 4;
    localparam int COORD_W = 64;
    localparam int CNT_W   = 3;
    localparam logic [63:0] SENT = 64'hFFFF_FFFF_FFFF_FFFF;

    logic               clock;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] in_coord;
    logic               in_last;
    logic [COORD_W-1:0] coord;
    logic               fetch_next;
    logic               empty;
    logic               fiber_done;
    logic               underflow;
    logic [CNT_W-1:0]   count;

    int checks = 0;
    int errors = 0;

    fiber_lane_buffer #(
        .DEPTH   (DEPTH),
        .COORD_W (COORD_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_coord   (in_coord),
        .in_last    (in_last),
        .coord      (coord),
        .fetch_next (fetch_next),
        .empty      (empty),
        .fiber_done (fiber_done),
        .underflow  (underflow),
        .count      (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        v;
        logic [63:0] c;
        logic        l;
        logic        f;
        logic [63:0] e_coord;
        logic        e_empty;
        logic        e_ready;
        logic [2:0]  e_count;
        logic        e_done;
        logic        e_uf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] e_coord, input logic e_empty,
                             input logic e_ready, input logic [2:0] e_count,
                             input logic e_done, input logic e_uf);
        check({tag, ".coord"},      coord,      e_coord);
        check({tag, ".empty"},      64'(empty),      64'(e_empty));
        check({tag, ".in_ready"},   64'(in_ready),   64'(e_ready));
        check({tag, ".count"},      64'(count),      64'(e_count));
        check({tag, ".fiber_done"}, 64'(fiber_done), 64'(e_done));
        check({tag, ".underflow"},  64'(underflow),  64'(e_uf));
    endtask

    function automatic void add(input string name, input logic v, input logic [63:0] c,
                                input logic l, input logic f, input logic [63:0] ec,
                                input logic ee, input logic er, input logic [2:0] en,
                                input logic ed, input logic eu);
        vec_t t;
        t.name = name; t.v = v; t.c = c; t.l = l; t.f = f;
        t.e_coord = ec; t.e_empty = ee; t.e_ready = er; t.e_count = en;
        t.e_done = ed; t.e_uf = eu;
        vecs.push_back(t);
    endfunction

    // Drive one set of inputs across one rising edge, then settle.
    task automatic cycle(input logic v, input logic [63:0] c, input logic l, input logic f);
        in_valid = v; in_coord = c; in_last = l; fetch_next = f;
        @(posedge clock);
        #1;
        in_valid = 1'b0; in_last = 1'b0; fetch_next = 1'b0; in_coord = '0;
    endtask

    initial begin
        //   name        v  coord l  f  exp_coord e  r  cnt done uf
        // Basic fiber 5, 9, 12(last), then drain.
        add("push5",     1, 5,    0, 0, 5,    0, 1, 1, 0, 0);
        add("push9",     1, 9,    0, 0, 5,    0, 1, 2, 0, 0);
        add("push12",    1, 12,   1, 0, 5,    0, 1, 3, 0, 0);
        add("pop5",      0, 0,    0, 1, 9,    0, 1, 2, 0, 0);
        add("pop9",      0, 0,    0, 1, 12,   0, 1, 1, 0, 0);
        add("pop12",     0, 0,    0, 1, SENT, 1, 1, 0, 1, 0);
        // Drain request after fiber end: silently ignored.
        add("drain",     0, 0,    0, 1, SENT, 1, 1, 0, 1, 0);
        // Empty lane, push and pop together: push wins, pop ignored, done clears.
        add("push20pop", 1, 20,   0, 1, 20,   0, 1, 1, 0, 0);
        add("pop20",     0, 0,    0, 1, SENT, 1, 1, 0, 0, 0);
        // Fill to full, hold 7 while full, pop frees a slot for 7.
        add("fill1",     1, 1,    0, 0, 1,    0, 1, 1, 0, 0);
        add("fill2",     1, 2,    0, 0, 1,    0, 1, 2, 0, 0);
        add("fill3",     1, 3,    0, 0, 1,    0, 1, 3, 0, 0);
        add("fill4",     1, 4,    0, 0, 1,    0, 0, 4, 0, 0);
        add("hold7",     1, 7,    0, 0, 1,    0, 0, 4, 0, 0);
        add("full_pop",  1, 7,    0, 1, 2,    0, 1, 3, 0, 0);
        add("take7",     1, 7,    0, 0, 2,    0, 0, 4, 0, 0);
        add("rd2",       0, 0,    0, 1, 3,    0, 1, 3, 0, 0);
        add("rd3",       0, 0,    0, 1, 4,    0, 1, 2, 0, 0);
        add("rd4",       0, 0,    0, 1, 7,    0, 1, 1, 0, 0);
        add("rd7",       0, 0,    0, 1, SENT, 1, 1, 0, 0, 0);
        // Pop while empty before fiber end: sticky underflow.
        add("uflow",     0, 0,    0, 1, SENT, 1, 1, 0, 0, 1);
        add("uf_hold",   0, 0,    0, 0, SENT, 1, 1, 0, 0, 1);
        add("push30L",   1, 30,   1, 0, 30,   0, 1, 1, 0, 1);
        add("pop30",     0, 0,    0, 1, SENT, 1, 1, 0, 1, 1);
        add("drain2",    0, 0,    0, 1, SENT, 1, 1, 0, 1, 1);
        // Push after done clears it; last-pop plus push on one edge sets it.
        add("push40L",   1, 40,   1, 0, 40,   0, 1, 1, 0, 1);
        add("push41pop", 1, 41,   0, 1, 41,   0, 1, 1, 1, 1);
        add("pop41",     0, 0,    0, 1, SENT, 1, 1, 0, 1, 1);

        in_valid = 1'b0; in_coord = '0; in_last = 1'b0; fetch_next = 1'b0;

        // Reset state.
        reset = 1'b1;
        #12;
        check_all("reset", SENT, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            cycle(vecs[i].v, vecs[i].c, vecs[i].l, vecs[i].f);
            check_all(vecs[i].name, vecs[i].e_coord, vecs[i].e_empty, vecs[i].e_ready,
                      vecs[i].e_count, vecs[i].e_done, vecs[i].e_uf);
        end

        // No bypass: an offered coordinate is not visible before its edge.
        in_valid = 1'b1; in_coord = 64'd50; in_last = 1'b0;
        #1;
        check("no_bypass.coord", coord, SENT);
        check("no_bypass.count", 64'(count), 64'd0);
        @(posedge clock);
        #1;
        check("after_push50.coord", coord, 64'd50);
        cycle(1'b1, 64'd51, 1'b0, 1'b0);
        cycle(1'b1, 64'd52, 1'b0, 1'b0);
        check("mid_fiber.count", 64'(count), 64'd3);

        // Asynchronous reset mid-fiber: takes effect before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", SENT, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        cycle(1'b1, 64'd60, 1'b0, 1'b0);
        check_all("post_reset_push", 64'd60, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stuck bench.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_fiber_lane_buffer

// File: doc/fiber_lane_buffer.md
Name: fiber_lane_buffer

Overview:
- Per-lane coordinate prefetch buffer that sits directly upstream of one merger input (coord_N / fetch_next[N]).
- Accepts a coordinate fiber from the memory-side fetch unit over a valid/ready handshake and holds it in a small circular FIFO.
- Presents the head coordinate to the merger and pops it when the merger asserts fetch_next.
- Drives an all-ones sentinel when no coordinate is available, so the merger never selects an empty lane ahead of a real coordinate.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- COORD_W, 64, coordinate width; must match the merger datapath.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream coordinate valid.
- in_ready  output  1  buffer can accept; equals !full and is registered-state only, with no combinational path from fetch_next.
- in_coord  input  COORD_W  incoming coordinate, ascending within a fiber; all-ones is reserved.
- in_last  input  1  marks the final coordinate of the fiber.
- coord  output  COORD_W  head coordinate, or SENTINEL (all ones) when empty.
- fetch_next  input  1  merger pop request for the head entry.
- empty  output  1  no stored entries.
- fiber_done  output  1  the last-flagged entry has been popped.
- underflow  output  1  sticky error flag.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset (asynchronous, active-high): all state is cleared immediately.
  - wr_ptr=0, rd_ptr=0, count=0, fiber_done=0, underflow=0.
  - Reset outputs: in_ready=1, empty=1, coord=SENTINEL.
  - Stored data is don't-care.
  - Reset asserted mid-fiber discards all entries; no partial state survives.
- Storage:
  - Circular FIFO of {last, coord} entries.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count tracks occupancy, so full = (count==DEPTH) and empty = (count==0).
- Push: occurs when in_valid && in_ready.
  - Writes {in_last, in_coord} at wr_ptr and increments wr_ptr.
- Pop: occurs when fetch_next && !empty.
  - Increments rd_ptr.
  - If the popped entry has last=1, fiber_done is set on that edge.
- Latency:
  - A pushed coordinate appears on coord in the cycle after the push edge.
  - After a pop, the next head appears in the cycle after the pop edge.
- coord: combinational read of mem[rd_ptr] when !empty, else SENTINEL.
- Simultaneous push and pop:
  - Non-empty and not full: both occur and count is unchanged.
  - Full: in_ready=0, so only the pop occurs; in_ready rises in the next cycle.
  - Empty: the push occurs and the pop is ignored, because the sentinel was being presented.
- Pop request when empty:
  - Has no effect on pointers or count.
  - If fiber_done=0, sets underflow, which is sticky until reset.
  - If fiber_done=1, this is a legal drain request from the merger once all lanes show the sentinel, and is ignored silently.
- fiber_done clear:
  - Cleared on the first accepted push after it was set; that push starts a new fiber.
  - A push and a last-pop on the same edge: fiber_done is set, because the set has priority. The new fiber's entry remains queued behind it.
- No bypass path: in_coord never reaches coord in the same cycle.
- An in_coord equal to SENTINEL is a protocol violation; the behaviour is undefined and the bench must not drive it.

Decomposition:
- Shared package merger_pkg holds:
  - COORD_W = 64.
  - SENTINEL = all ones (the all-ones value of COORD_W bits).
  - The typedef coord_t.
  - The typedef lane_entry_t, a packed struct of last and coord_t.
- Quaternary and binary mergers use the same package constants.
- No sub-module: the FIFO is small enough to stay inline.
- A quad_lane_front wrapper later instantiates four fiber_lane_buffer blocks to feed coord_0..coord_3 and fetch_next[3:0].

Test Plan:
- Reset then idle -> coord=64'hFFFF_FFFF_FFFF_FFFF, empty=1, in_ready=1, count=0. Assert reset mid-fiber with 3 entries stored -> the same values appear immediately, before any clock edge.
- Push 5,9,12(last) on consecutive cycles, then pulse fetch_next three times -> coord shows 5 one cycle after the first push, then 9 and 12. fiber_done=1 after the third pop; coord returns to SENTINEL.
- Fill with 1,2,3,4 and hold in_valid with 7 -> in_ready=0 at count=4. Assert fetch_next -> 1 is popped; 7 is accepted the next cycle; count stays 4; pointer wrap is verified by reading out 2,3,4,7.
- Empty buffer, same-cycle push of 20 and fetch_next -> push accepted, pop ignored; coord=20 next cycle; count=1; underflow=0 after the final fiber_done check.
- fetch_next while empty with fiber_done=0 -> underflow=1 and stays set. Then finish a fiber and pulse fetch_next while empty -> no additional effect.
- After fiber_done=1, push 40 -> fiber_done clears on that edge and coord=40 next cycle. Push with last and pop of the last entry on the same edge -> fiber_done=1, count unchanged.
